// File: rtl/multi_stepper_ctrl_if.sv
// Per-channel step-command bundle between a motion host and multi_stepper_ctrl.
// Channel c occupies bit c of the scalars and slice [c*W +: W] of the packed fields.
interface multi_stepper_ctrl_if #(
  parameter int unsigned NUM_CH   = 2,
  parameter int unsigned PERIOD_W = 24,
  parameter int unsigned COUNT_W  = 16
);
  logic [NUM_CH-1:0]          cmd_valid;
  logic [NUM_CH-1:0]          cmd_ready;
  logic [NUM_CH-1:0]          cmd_dir;
  logic [NUM_CH-1:0]          cmd_half;
  logic [NUM_CH*COUNT_W-1:0]  cmd_steps;
  logic [NUM_CH*PERIOD_W-1:0] cmd_period;

  modport master (
    output cmd_valid, cmd_dir, cmd_half, cmd_steps, cmd_period,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_dir, cmd_half, cmd_steps, cmd_period,
    output cmd_ready
  );
endinterface

// File: rtl/multi_stepper_ctrl.sv
// N-channel unipolar stepper sequencer: each channel runs its own IDLE/RUN/PAUSE/DONE FSM
// and walks an 8-entry half-step phase table at a commanded step period.
module multi_stepper_ctrl #(
  parameter int unsigned NUM_CH   = 2,
  parameter int unsigned PERIOD_W = 24,
  parameter int unsigned COUNT_W  = 16,
  parameter bit          HOLD     = 1'b0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      pause_i,
  multi_stepper_ctrl_if.slave       cmd_if,
  input  logic [NUM_CH-1:0]         abort_i,
  output logic [4*NUM_CH-1:0]       coil_o,
  output logic [NUM_CH-1:0]         busy_o,
  output logic [NUM_CH-1:0]         done_o,
  output logic [NUM_CH*COUNT_W-1:0] steps_left_o
);

  typedef enum logic [1:0] {StIdle, StRun, StPause, StDone} state_e;

  function automatic logic [3:0] phase_coil(input logic [2:0] p);
    logic [3:0] c;
    unique case (p)
      3'd0: c = 4'b1000;
      3'd1: c = 4'b1100;
      3'd2: c = 4'b0100;
      3'd3: c = 4'b0110;
      3'd4: c = 4'b0010;
      3'd5: c = 4'b0011;
      3'd6: c = 4'b0001;
      3'd7: c = 4'b1001;
      default: c = 4'b0000;
    endcase
    return c;
  endfunction

  localparam logic [3:0] CoilRst = HOLD ? 4'b1100 : 4'b0000;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    state_e              state_q, state_d;
    logic [2:0]          p_q, p_d;
    logic [PERIOD_W-1:0] cnt_q, cnt_d, period_q, period_d;
    logic [COUNT_W-1:0]  left_q, left_d;
    logic                dir_q, dir_d, half_q, half_d;
    logic [3:0]          coil_q, coil_d;
    logic                busy_q, busy_d, done_q, done_d;
    logic [PERIOD_W-1:0] period_in;
    logic [COUNT_W-1:0]  steps_in;

    assign period_in = cmd_if.cmd_period[c*PERIOD_W +: PERIOD_W];
    assign steps_in  = cmd_if.cmd_steps[c*COUNT_W +: COUNT_W];

    always_comb begin
      state_d  = state_q;
      p_d      = p_q;
      cnt_d    = cnt_q;
      period_d = period_q;
      left_d   = left_q;
      dir_d    = dir_q;
      half_d   = half_q;
      unique case (state_q)
        StIdle: begin
          if (cmd_if.cmd_valid[c]) begin
            dir_d    = cmd_if.cmd_dir[c];
            half_d   = cmd_if.cmd_half[c];
            period_d = (period_in < PERIOD_W'(2)) ? PERIOD_W'(2) : period_in;
            left_d   = steps_in;
            cnt_d    = '0;
            state_d  = (steps_in == '0) ? StDone : StRun;
          end
        end
        StRun, StPause: begin
          // Abort outranks pause and any step due this cycle.
          if (abort_i[c]) begin
            state_d = StIdle;
            left_d  = '0;
          end else if (pause_i) begin
            state_d = StPause;
          end else begin
            state_d = StRun;
            if (cnt_q == period_q - PERIOD_W'(1)) begin
              cnt_d  = '0;
              p_d    = dir_q ? p_q + (half_q ? 3'd1 : 3'd2) : p_q - (half_q ? 3'd1 : 3'd2);
              left_d = left_q - COUNT_W'(1);
              if (left_q == COUNT_W'(1)) state_d = StDone;
            end else begin
              cnt_d = cnt_q + PERIOD_W'(1);
            end
          end
        end
        StDone:  state_d = StIdle;
        default: state_d = StIdle;
      endcase

      busy_d = (state_d == StRun) || (state_d == StPause);
      done_d = (state_d == StDone);
      coil_d = (state_d == StIdle && !HOLD) ? 4'b0000 : phase_coil(p_d);
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        state_q  <= StIdle;
        p_q      <= 3'd1;
        cnt_q    <= '0;
        period_q <= PERIOD_W'(2);
        left_q   <= '0;
        dir_q    <= 1'b0;
        half_q   <= 1'b0;
        coil_q   <= CoilRst;
        busy_q   <= 1'b0;
        done_q   <= 1'b0;
      end else begin
        state_q  <= state_d;
        p_q      <= p_d;
        cnt_q    <= cnt_d;
        period_q <= period_d;
        left_q   <= left_d;
        dir_q    <= dir_d;
        half_q   <= half_d;
        coil_q   <= coil_d;
        busy_q   <= busy_d;
        done_q   <= done_d;
      end
    end

    assign cmd_if.cmd_ready[c]                = (state_q == StIdle);
    assign coil_o[4*c +: 4]                   = coil_q;
    assign busy_o[c]                          = busy_q;
    assign done_o[c]                          = done_q;
    assign steps_left_o[c*COUNT_W +: COUNT_W] = left_q;
  end

endmodule

// File: tb/tb_multi_stepper_ctrl.sv
// Directed bench for multi_stepper_ctrl (2 channels, HOLD = 0) with hand-computed coil,
// busy, done, ready and steps_left expectations.
module tb_multi_stepper_ctrl;
  localparam int unsigned NUM_CH   = 2;
  localparam int unsigned PERIOD_W = 24;
  localparam int unsigned COUNT_W  = 16;

  logic                      clk = 1'b0;
  logic                      rst;
  logic                      pause_i;
  logic [NUM_CH-1:0]         abort_i;
  logic [4*NUM_CH-1:0]       coil_o;
  logic [NUM_CH-1:0]         busy_o;
  logic [NUM_CH-1:0]         done_o;
  logic [NUM_CH*COUNT_W-1:0] steps_left_o;

  int n_vec = 0;
  int n_err = 0;

  logic [3:0] tbl [8] = '{4'b1000, 4'b1100, 4'b0100, 4'b0110,
                          4'b0010, 4'b0011, 4'b0001, 4'b1001};

  multi_stepper_ctrl_if #(.NUM_CH(NUM_CH), .PERIOD_W(PERIOD_W), .COUNT_W(COUNT_W)) cmd_if ();

  multi_stepper_ctrl #(
    .NUM_CH  (NUM_CH),
    .PERIOD_W(PERIOD_W),
    .COUNT_W (COUNT_W),
    .HOLD    (1'b0)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .pause_i     (pause_i),
    .cmd_if      (cmd_if),
    .abort_i     (abort_i),
    .coil_o      (coil_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .steps_left_o(steps_left_o)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Presents a command on channel ch and advances through the accept edge (T0).
  task automatic send(input int ch, input logic dir, input logic half,
                      input logic [COUNT_W-1:0] steps, input logic [PERIOD_W-1:0] period);
    cmd_if.cmd_dir[ch]                      = dir;
    cmd_if.cmd_half[ch]                     = half;
    cmd_if.cmd_steps[ch*COUNT_W +: COUNT_W]    = steps;
    cmd_if.cmd_period[ch*PERIOD_W +: PERIOD_W] = period;
    cmd_if.cmd_valid[ch]                    = 1'b1;
    tick();
    cmd_if.cmd_valid[ch] = 1'b0;
  endtask

  initial begin
    int s0, s1;
    logic [3:0] c0, c1;
    rst                = 1'b1;
    pause_i            = 1'b0;
    abort_i            = '0;
    cmd_if.cmd_valid   = '0;
    cmd_if.cmd_dir     = '0;
    cmd_if.cmd_half    = '0;
    cmd_if.cmd_steps   = '0;
    cmd_if.cmd_period  = '0;
    ticks(2);
    rst = 1'b0;

    check_val("rst_coil", coil_o, 8'h00);
    check_val("rst_busy", busy_o, 2'b00);
    check_val("rst_done", done_o, 2'b00);
    check_val("rst_left", steps_left_o, 32'h0);
    check_val("rst_ready", cmd_if.cmd_ready, 2'b11);

    // Full-step forward, ch0, S=4, P=10, from p=1.
    send(0, 1'b1, 1'b0, 16'd4, 24'd10);
    check_val("fs_busy0", busy_o[0], 1'b1);
    check_val("fs_ready0", cmd_if.cmd_ready[0], 1'b0);
    check_val("fs_coil0", coil_o[3:0], 4'b1100);
    ticks(9);
    check_val("fs_coil9", coil_o[3:0], 4'b1100);
    tick();
    check_val("fs_coil10", coil_o[3:0], 4'b0110);
    check_val("fs_left10", steps_left_o[15:0], 16'd3);
    ticks(10);
    check_val("fs_coil20", coil_o[3:0], 4'b0011);
    ticks(10);
    check_val("fs_coil30", coil_o[3:0], 4'b1001);
    check_val("fs_done30", done_o[0], 1'b0);
    ticks(10);
    check_val("fs_coil40", coil_o[3:0], 4'b1100);
    check_val("fs_done40", done_o[0], 1'b1);
    check_val("fs_ready40", cmd_if.cmd_ready[0], 1'b0);
    tick();
    check_val("fs_done41", done_o[0], 1'b0);
    check_val("fs_ready41", cmd_if.cmd_ready[0], 1'b1);
    check_val("fs_idlecoil", coil_o[3:0], 4'b0000);

    // Half-step reverse, ch1, S=3, P=5, from p=1.
    send(1, 1'b0, 1'b1, 16'd3, 24'd5);
    check_val("hs_left0", steps_left_o[31:16], 16'd3);
    ticks(5);
    check_val("hs_coil5", coil_o[7:4], 4'b1000);
    check_val("hs_left5", steps_left_o[31:16], 16'd2);
    ticks(5);
    check_val("hs_coil10", coil_o[7:4], 4'b1001);
    check_val("hs_left10", steps_left_o[31:16], 16'd1);
    ticks(5);
    check_val("hs_coil15", coil_o[7:4], 4'b0001);
    check_val("hs_left15", steps_left_o[31:16], 16'd0);
    check_val("hs_done15", done_o, 2'b10);
    tick();

    // Pause sampled high on edges T0+5..T0+9 delays each step by five cycles.
    send(0, 1'b1, 1'b0, 16'd2, 24'd10);
    ticks(4);
    pause_i = 1'b1;
    ticks(3);
    check_val("ps_busy7", busy_o[0], 1'b1);
    ticks(2);
    pause_i = 1'b0;
    ticks(5);
    check_val("ps_coil14", coil_o[3:0], 4'b1100);
    tick();
    check_val("ps_coil15", coil_o[3:0], 4'b0110);
    check_val("ps_left15", steps_left_o[15:0], 16'd1);
    ticks(9);
    check_val("ps_done24", done_o[0], 1'b0);
    tick();
    check_val("ps_coil25", coil_o[3:0], 4'b0011);
    check_val("ps_done25", done_o[0], 1'b1);
    tick();

    // Abort on ch0 after two steps (p: 5 -> 7 -> 1).
    send(0, 1'b1, 1'b0, 16'd100, 24'd4);
    ticks(8);
    check_val("ab_coil8", coil_o[3:0], 4'b1100);
    check_val("ab_left8", steps_left_o[15:0], 16'd98);
    abort_i[0] = 1'b1;
    tick();
    abort_i[0] = 1'b0;
    check_val("ab_ready", cmd_if.cmd_ready[0], 1'b1);
    check_val("ab_busy", busy_o[0], 1'b0);
    check_val("ab_left", steps_left_o[15:0], 16'd0);
    check_val("ab_coil", coil_o[3:0], 4'b0000);
    check_val("ab_done", done_o[0], 1'b0);
    tick();
    check_val("ab_done2", done_o[0], 1'b0);

    // S = 0: straight to DONE, p stays 1.
    send(0, 1'b1, 1'b0, 16'd0, 24'd10);
    check_val("s0_done", done_o[0], 1'b1);
    check_val("s0_coil", coil_o[3:0], 4'b1100);
    check_val("s0_busy", busy_o[0], 1'b0);
    tick();
    check_val("s0_done2", done_o[0], 1'b0);
    check_val("s0_ready", cmd_if.cmd_ready[0], 1'b1);

    // P = 1 clamps to 2: ch1 half forward from p=6.
    send(1, 1'b1, 1'b1, 16'd2, 24'd1);
    tick();
    check_val("p1_coil1", coil_o[7:4], 4'b0001);
    tick();
    check_val("p1_coil2", coil_o[7:4], 4'b1001);
    ticks(2);
    check_val("p1_coil4", coil_o[7:4], 4'b1000);
    check_val("p1_done4", done_o[1], 1'b1);
    tick();

    // Reset mid-move.
    send(0, 1'b1, 1'b1, 16'd5, 24'd3);
    ticks(6);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_val("mr_coil", coil_o, 8'h00);
    check_val("mr_busy", busy_o, 2'b00);
    check_val("mr_done", done_o, 2'b00);
    check_val("mr_left", steps_left_o, 32'h0);
    check_val("mr_ready", cmd_if.cmd_ready, 2'b11);

    // Concurrent moves from p=1 on both channels.
    cmd_if.cmd_dir    = 2'b11;
    cmd_if.cmd_half   = 2'b00;
    cmd_if.cmd_steps  = {16'd5, 16'd5};
    cmd_if.cmd_period = {24'd7, 24'd3};
    cmd_if.cmd_valid  = 2'b11;
    tick();
    cmd_if.cmd_valid  = 2'b00;
    for (int k = 1; k <= 37; k++) begin
      tick();
      s0 = (k / 3 > 5) ? 5 : k / 3;
      s1 = (k / 7 > 5) ? 5 : k / 7;
      c0 = (k >= 16) ? 4'b0000 : tbl[(1 + 2 * s0) % 8];
      c1 = (k >= 36) ? 4'b0000 : tbl[(1 + 2 * s1) % 8];
      check_val($sformatf("cc_coil_%0d", k), coil_o, {c1, c0});
      check_val($sformatf("cc_done_%0d", k), done_o, {(k == 35), (k == 15)});
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/multi_stepper_ctrl.md
# multi_stepper_ctrl

Parametrised N-channel unipolar stepper-motor sequencer. It replaces the fixed single-pattern move/cut coil drivers with one block that serves every motor in the slicer: a mover, a cutter, and any added axis. Each channel accepts a step command (count, direction, step period, full/half mode), generates the 4-wire coil sequence at that rate, and reports busy, remaining steps and completion. A global pause freezes every channel; a per-channel abort cancels that channel's move.

## Interface
- NUM_CH, 2, number of independent motor channels (1..8)
- PERIOD_W, 24, width of step-period field, in clk cycles (50 MHz: 1 ms = 50_000)
- COUNT_W, 16, width of step-count field
- HOLD, 0, 1 keeps the last coil pattern energised when idle; 0 drives 4'b0000 when idle

Ports:
- clk  in  1  system clock, 50 MHz
- rst  in  1  synchronous, active-high reset
- pause_i  in  1  global pause level; freezes all channels while high
- cmd_valid_i  in  NUM_CH  per-channel command strobe
- cmd_ready_o  out  NUM_CH  per-channel ready; high only in IDLE
- cmd_dir_i  in  NUM_CH  1 = forward (phase index +), 0 = reverse
- cmd_half_i  in  NUM_CH  1 = half-step, 0 = full-step (two-phase-on)
- cmd_steps_i  in  NUM_CH*COUNT_W  steps to execute, channel c at [c*COUNT_W +: COUNT_W]
- cmd_period_i  in  NUM_CH*PERIOD_W  clk cycles per step, same packing
- abort_i  in  NUM_CH  per-channel abort, level
- coil_o  out  4*NUM_CH  coil drive, channel c at [4c +: 4], bit3..bit0 = A,B,C,D
- busy_o  out  NUM_CH  high in RUN or PAUSE
- done_o  out  NUM_CH  one-cycle pulse on normal completion
- steps_left_o  out  NUM_CH*COUNT_W  steps still to execute

## Operation
- Per-channel FSM: IDLE, RUN, PAUSE, DONE. Channels are fully independent apart from pause_i.
- Phase table, 3-bit index p: 0:1000, 1:1100, 2:0100, 3:0110, 4:0010, 5:0011, 6:0001, 7:1001.
- Each step moves p by ±1 in half mode and ±2 in full mode, modulo 8. Parity is preserved in full mode, so full steps from an odd p always use two-coil patterns.
- p is held across commands. Reset sets p = 1.
- IDLE: cmd_ready_o = 1. Accept on cmd_valid_i & cmd_ready_o.
  - The accept latches dir, half, steps and period.
  - A period below 2 is clamped to 2.
  - Steps = 0 goes IDLE→DONE directly with no coil change. Otherwise IDLE→RUN with the period counter cleared.
- RUN: the counter increments each cycle. When it reaches period−1, in the same cycle:
  - p updates and the counter clears;
  - steps_left decrements;
  - if steps_left was 1, the FSM moves to DONE.
- RUN→PAUSE when pause_i = 1. The counter and coils are frozen. PAUSE→RUN when pause_i = 0, resuming the count where it stopped.
- DONE: done_o = 1 for exactly one cycle, then IDLE.
- abort_i = 1 in RUN or PAUSE: next state is IDLE, steps_left is cleared, and done_o is not pulsed. p keeps its current value.
- abort_i in IDLE or DONE is ignored. Abort wins over pause and over a step that falls due in the same cycle (no p update that cycle).
- pause_i does not block command acceptance. A command accepted while pause_i = 1 enters RUN and moves to PAUSE on the next cycle.
- coil_o = table[p] in RUN, PAUSE and DONE. In IDLE, coil_o = table[p] if HOLD = 1, else 0000.

## Timing
- All outputs are registered except cmd_ready_o, which is decoded from the FSM state.
- Reset values: FSM IDLE, p = 1, steps_left_o = 0, busy_o = 0, done_o = 0, cmd_ready_o = 1 after the reset edge, coil_o = 0000 (HOLD = 0) or 1100 (HOLD = 1).
- Accept at edge T0. Step k updates coil_o at edge T0 + k·P, for k = 1..S.
- done_o is high in the cycle after edge T0 + S·P. cmd_ready_o returns one cycle after that.
- With S = 0, done_o is high in the cycle after T0.
- Each paused cycle delays every later step edge by one cycle.
- Reset asserted mid-move returns the channel to IDLE with the reset values above. No done_o pulse.

## Test plan
- Full-step forward: ch0, dir = 1, half = 0, S = 4, P = 10. Expect coil_o[3:0] = 1100→0110→0011→1001→1100 at T0+10/20/30/40, then done_o at T0+41 and cmd_ready_o = 1 at T0+42.
- Half-step reverse: ch1, dir = 0, half = 1, S = 3, P = 5, from p = 1. Expect coils 1000, 1001, 0001 at T0+5/10/15. steps_left_o goes 3→2→1→0.
- Pause: ch0, S = 2, P = 10, with pause_i high from T0+4 to T0+9. Expect steps at T0+15 and T0+25, busy_o held high, done_o at T0+26.
- Abort: ch0, S = 100, P = 4, abort_i at T0+9. Expect two steps to have occurred, IDLE next cycle, steps_left_o = 0, no done_o, and coil_o = 0000 with HOLD = 0.
- Boundaries:
  - S = 0: done_o at T0+1 and coil_o unchanged.
  - P = 1: behaves as P = 2.
  - Reset at T0+7 of a move: all outputs return to their reset values.
- Concurrency: ch0 P = 3, ch1 P = 7, both with S = 5 and accepted at the same edge. Expect independent step edges, done_o[0] at T0+16 and done_o[1] at T0+36.
